// File: rtl/rgen_apb_master.sv
// rgen_apb_master: single-outstanding command/response to APB4 initiator.
// Sequences SETUP/ACCESS, waits on pready, aborts stalled transfers on timeout.
`timescale 1ns/1ps
module rgen_apb_master #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_command_valid,
    output logic                      o_command_ready,
    input  logic                      i_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_strobe,
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic [DATA_WIDTH-1:0]     o_read_data,
    output logic [1:0]                o_status,
    output logic [ADDRESS_WIDTH-1:0]  o_paddr,
    output logic [2:0]                o_pprot,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [DATA_WIDTH-1:0]     o_pwdata,
    output logic [DATA_WIDTH/8-1:0]   o_pstrb,
    input  logic                      i_pready,
    input  logic                      i_pslverr,
    input  logic [DATA_WIDTH-1:0]     i_prdata
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESPONSE
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [ADDRESS_WIDTH-1:0] paddr_d;
    logic                 pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic [SW-1:0]        pstrb_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]           status_d;

    assign o_pprot = 3'b000;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        paddr_d  = o_paddr;
        pwrite_d = o_pwrite;
        pwdata_d = o_pwdata;
        pstrb_d  = o_pstrb;
        rdata_d  = o_read_data;
        status_d = o_status;
        unique case (state)
            IDLE: begin
                if (i_command_valid) begin
                    state_d  = SETUP;
                    paddr_d  = i_address;
                    pwrite_d = i_write;
                    pwdata_d = i_write ? i_write_data : '0;
                    pstrb_d  = i_write ? i_strobe : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                // pready takes priority over a timeout in the same cycle
                if (i_pready) begin
                    state_d  = RESPONSE;
                    rdata_d  = o_pwrite ? '0 : i_prdata;
                    status_d = {1'b0, i_pslverr};
                end else if (TO_EN && cnt == CNT_LAST) begin
                    state_d  = RESPONSE;
                    rdata_d  = '0;
                    status_d = 2'b10;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RESPONSE: begin
                if (i_response_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control outputs are flopped from the next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            o_paddr          <= '0;
            o_pwrite         <= 1'b0;
            o_pwdata         <= '0;
            o_pstrb          <= '0;
            o_read_data      <= '0;
            o_status         <= 2'b00;
            o_command_ready  <= 1'b1;
            o_psel           <= 1'b0;
            o_penable        <= 1'b0;
            o_response_valid <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            o_paddr          <= paddr_d;
            o_pwrite         <= pwrite_d;
            o_pwdata         <= pwdata_d;
            o_pstrb          <= pstrb_d;
            o_read_data      <= rdata_d;
            o_status         <= status_d;
            o_command_ready  <= (state_d == IDLE);
            o_psel           <= (state_d == SETUP) || (state_d == ACCESS);
            o_penable        <= (state_d == ACCESS);
            o_response_valid <= (state_d == RESPONSE);
        end
    end

endmodule

// File: tb/tb_rgen_apb_master.sv
// tb_rgen_apb_master: directed scoreboard bench for rgen_apb_master.
// Responder model and monitors run beside the stimulus process.
`timescale 1ns/1ps
module tb_rgen_apb_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_command_valid = 1'b0;
    logic          o_command_ready;
    logic          i_write = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [DW-1:0] i_write_data = '0;
    logic [SW-1:0] i_strobe = '0;
    logic          o_response_valid;
    logic          i_response_ready = 1'b1;
    logic [DW-1:0] o_read_data;
    logic [1:0]    o_status;
    logic [AW-1:0] o_paddr;
    logic [2:0]    o_pprot;
    logic          o_psel;
    logic          o_penable;
    logic          o_pwrite;
    logic [DW-1:0] o_pwdata;
    logic [SW-1:0] o_pstrb;
    logic          i_pready;
    logic          i_pslverr;
    logic [DW-1:0] i_prdata;

    always #5 clk = ~clk;

    rgen_apb_master #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_command_valid(i_command_valid),
        .o_command_ready(o_command_ready),
        .i_write(i_write),
        .i_address(i_address),
        .i_write_data(i_write_data),
        .i_strobe(i_strobe),
        .o_response_valid(o_response_valid),
        .i_response_ready(i_response_ready),
        .o_read_data(o_read_data),
        .o_status(o_status),
        .o_paddr(o_paddr),
        .o_pprot(o_pprot),
        .o_psel(o_psel),
        .o_penable(o_penable),
        .o_pwrite(o_pwrite),
        .o_pwdata(o_pwdata),
        .o_pstrb(o_pstrb),
        .i_pready(i_pready),
        .i_pslverr(i_pslverr),
        .i_prdata(i_prdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Responder: pready after r_wait stalled ACCESS cycles unless hung
    logic          r_hang = 1'b0;
    logic          r_err = 1'b0;
    int            r_wait = 0;
    logic [DW-1:0] r_rdata = '0;
    int            acc;

    assign i_pready  = o_psel & o_penable & ~r_hang & (acc >= r_wait);
    assign i_pslverr = i_pready & r_err;
    assign i_prdata  = r_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= 0;
        else if (o_psel && o_penable && !i_pready) acc <= acc + 1;
        else acc <= 0;
    end

    typedef struct {
        logic [DW-1:0] rd;
        logic [1:0]    st;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } bus_t;

    exp_t sbq[$];
    bus_t bq[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response monitor: compare on each response handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && o_response_valid && i_response_ready) begin
                if (sbq.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_data", o_read_data, e.rd);
                    chk("resp_status", o_status, e.st);
                end
            end
        end
    end

    // Bus monitor: expected SETUP contents and stability through ACCESS
    initial begin
        bus_t b;
        logic [52:0] snap;
        logic prev_psel;
        prev_psel = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            #1;
            if (o_psel && !o_penable) begin
                chk("psel_gap", prev_psel, 0);
                snap = {o_paddr, o_pwrite, o_pwdata, o_pstrb};
                if (bq.size() == 0) begin
                    chk("bus_unexpected", 1, 0);
                end else begin
                    b = bq.pop_front();
                    chk("bus_setup", snap, {b.a, b.w, b.d, b.s});
                end
            end else if (o_psel && o_penable) begin
                chk("bus_stable", {o_paddr, o_pwrite, o_pwdata, o_pstrb}, snap);
            end
            prev_psel = o_psel;
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [DW-1:0] erd, input logic [1:0] est);
        int t;
        t = 0;
        while (!o_command_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("cmd_ready_wait", 0, 1);
        i_command_valid = 1'b1;
        i_write = w;
        i_address = a;
        i_write_data = d;
        i_strobe = s;
        sbq.push_back('{rd: erd, st: est});
        bq.push_back('{a: a, w: w, d: (w ? d : '0), s: (w ? s : '0)});
        @(posedge clk);
        @(negedge clk);
        i_command_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!o_response_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("resp_wait", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_ctrl",
            {o_psel, o_penable, o_response_valid, o_pwrite, o_status}, 0);
        chk("reset_bus", {o_paddr, o_pwdata, o_pstrb, o_pprot}, 0);
        chk("reset_rdata", o_read_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", o_command_ready, 1);

        // zero-wait write
        issue(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
        chk("w0_setup", {o_psel, o_penable}, 2'b10);
        chk("w0_pstrb", o_pstrb, 4'hF);
        @(negedge clk);
        chk("w0_access", {o_psel, o_penable}, 2'b11);
        @(negedge clk);
        chk("w0_resp", {o_response_valid, o_psel, o_penable}, 3'b100);
        @(negedge clk);
        chk("w0_idle", {o_command_ready, o_response_valid}, 2'b10);

        // read with 3 wait states; pready on the 4th ACCESS cycle beats timeout
        r_wait = 3;
        r_rdata = 32'h12345678;
        issue(1'b0, 16'h0008, 32'hFFFFFFFF, 4'hF, 32'h12345678, 2'b00);
        wait_resp(n);
        chk("r3_latency", n, 5);
        @(negedge clk);

        // slave error on write
        r_wait = 0;
        r_err = 1'b1;
        issue(1'b1, 16'h0010, 32'hA5A5A5A5, 4'h3, 32'h0, 2'b01);
        wait_resp(n);
        chk("err_latency", n, 2);
        chk("err_psel_drop", {o_psel, o_penable}, 2'b00);
        @(negedge clk);
        r_err = 1'b0;

        // timeout: read data forced to zero
        r_hang = 1'b1;
        r_rdata = 32'hCAFEF00D;
        issue(1'b0, 16'h0020, 32'h0, 4'h0, 32'h0, 2'b10);
        wait_resp(n);
        chk("to_latency", n, 5);
        chk("to_psel_drop", o_psel, 0);
        @(negedge clk);
        r_hang = 1'b0;

        // response backpressure
        i_response_ready = 1'b0;
        r_wait = 1;
        r_rdata = 32'h0BADF00D;
        issue(1'b0, 16'h000C, 32'h0, 4'h0, 32'h0BADF00D, 2'b00);
        wait_resp(n);
        chk("bp_latency", n, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold",
                {o_response_valid, o_command_ready, o_read_data, o_status},
                {1'b1, 1'b0, 32'h0BADF00D, 2'b00});
        end
        i_response_ready = 1'b1;
        @(negedge clk);

        // back-to-back: second command held valid during the first response
        r_wait = 0;
        r_rdata = 32'h600DCAFE;
        issue(1'b1, 16'h0014, 32'h11223344, 4'hF, 32'h0, 2'b00);
        wait_resp(n);
        i_command_valid = 1'b1;
        i_write = 1'b0;
        i_address = 16'h0018;
        sbq.push_back('{rd: 32'h600DCAFE, st: 2'b00});
        bq.push_back('{a: 16'h0018, w: 1'b0, d: '0, s: '0});
        @(negedge clk);
        chk("b2b_gap", {o_command_ready, o_psel}, 2'b10);
        @(negedge clk);
        i_command_valid = 1'b0;
        chk("b2b_second", {o_psel, o_penable, o_paddr}, {2'b10, 16'h0018});
        wait_resp(n);
        @(negedge clk);

        // async reset during ACCESS
        r_hang = 1'b1;
        issue(1'b0, 16'h0008, 32'h0, 4'h0, 32'h0, 2'b00);
        @(negedge clk);
        chk("rst_in_access", {o_psel, o_penable}, 2'b11);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {o_psel, o_penable, o_response_valid}, 3'b000);
        sbq.delete();
        bq.delete();
        r_hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", o_command_ready, 1);
        r_rdata = 32'h55AA55AA;
        issue(1'b0, 16'h0008, 32'h0, 4'h0, 32'h55AA55AA, 2'b00);
        wait_resp(n);
        chk("rst_fresh_latency", n, 2);
        @(negedge clk);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
